key_breath_ctrl: RTL and testbench

Push-button front end that generates the `valid` enable consumed by the 4-LED breathing stage. It synchronises and debounces a raw active-low key, classifies each press as short or long, and toggles or clears a registered `valid` level accordingly. It sits directly upstream of the breathing LED block; `valid` connects straight to that block's enable input.

---
 rtl/key_ctrl_pkg.sv | 20 ++
 rtl/key_sync.sv | 23 ++
 rtl/key_breath_ctrl.sv | 155 +++++++++++++++
 tb/tb_key_breath_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_ctrl_pkg.sv
// Shared types and default timing constants for push-button key front ends.
package key_ctrl_pkg;

  localparam int unsigned KEY_DEBOUNCE_CYC = 1_000_000;
  localparam int unsigned KEY_LONG_CYC     = 100_000_000;
  localparam int unsigned KEY_AUTO_OFF_CYC = 1_500_000_000;

  typedef enum logic [1:0] {
    KEY_IDLE       = 2'd0,
    KEY_DB_PRESS   = 2'd1,
    KEY_HELD       = 2'd2,
    KEY_DB_RELEASE = 2'd3
  } key_state_t;

  // Counter width able to hold 0..lim-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned lim);
    return (lim > 1) ? int'($clog2(lim)) : 1;
  endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for an asynchronous key input with a configurable reset level.
module key_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_breath_ctrl.sv
// Debounced short/long key classifier driving the breathing-LED enable level.
// Optional auto-off of `valid` is built when AUTO_OFF_EN is defined.
module key_breath_ctrl
  import key_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = KEY_DEBOUNCE_CYC,
  parameter int unsigned LONG_CYC     = KEY_LONG_CYC,
  parameter int unsigned AUTO_OFF_CYC = KEY_AUTO_OFF_CYC
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic key_in,
  output logic valid,
  output logic key_short,
  output logic key_long
);

  localparam int unsigned DB_W   = cnt_w(DEBOUNCE_CYC);
  localparam int unsigned HOLD_W = cnt_w(LONG_CYC);

  // Debounce completes on the edge the counter would reach DEBOUNCE_CYC-1.
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 2);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);

  if (DEBOUNCE_CYC < 2 || LONG_CYC <= DEBOUNCE_CYC || AUTO_OFF_CYC < 2) begin : g_bad_cfg
    $error("key_breath_ctrl: invalid timing parameters");
  end

  logic              key_s;
  key_state_t        state_q, state_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              long_flag_q, long_flag_d;
  logic              valid_d, key_short_d, key_long_d;

`ifdef AUTO_OFF_EN
  localparam int unsigned AO_W = cnt_w(AUTO_OFF_CYC);
  localparam logic [AO_W-1:0] AO_LAST = AO_W'(AUTO_OFF_CYC - 1);

  logic [AO_W-1:0] ao_cnt_q, ao_cnt_d;
`endif

  key_sync #(.RST_VAL(1'b1)) u_key_sync (
    .sys_clk (sys_clk),
    .rst     (rst),
    .d       (key_in),
    .q       (key_s)
  );

  // Next-state, counter and event decode.
  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    long_flag_d = long_flag_q;
    key_short_d = 1'b0;
    key_long_d  = 1'b0;

    case (state_q)
      KEY_IDLE: begin
        if (!key_s) begin
          state_d     = KEY_DB_PRESS;
          db_cnt_d    = '0;
          hold_cnt_d  = '0;
          long_flag_d = 1'b0;
        end
      end
      KEY_DB_PRESS: begin
        if (key_s) begin
          state_d = KEY_IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = KEY_HELD;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      KEY_HELD: begin
        if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
        if (hold_cnt_q == HOLD_LAST && !long_flag_q) begin
          long_flag_d = 1'b1;
          key_long_d  = 1'b1;
        end
        if (key_s) begin
          state_d  = KEY_DB_RELEASE;
          db_cnt_d = '0;
        end
      end
      KEY_DB_RELEASE: begin
        if (!key_s) begin
          state_d = KEY_HELD;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = KEY_IDLE;
          key_short_d = !long_flag_q;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      default: state_d = KEY_IDLE;
    endcase
  end

  // Enable level: key events take priority over the auto-off timeout.
  always_comb begin
    valid_d = valid;
`ifdef AUTO_OFF_EN
    ao_cnt_d = '0;
    if (key_short_d) begin
      valid_d = !valid;
    end else if (key_long_d) begin
      valid_d = 1'b0;
    end else if (valid) begin
      if (ao_cnt_q == AO_LAST) begin
        valid_d = 1'b0;
      end else begin
        ao_cnt_d = ao_cnt_q + AO_W'(1);
      end
    end
`else
    if (key_short_d) begin
      valid_d = !valid;
    end else if (key_long_d) begin
      valid_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= KEY_IDLE;
      db_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      long_flag_q <= 1'b0;
      valid       <= 1'b0;
      key_short   <= 1'b0;
      key_long    <= 1'b0;
`ifdef AUTO_OFF_EN
      ao_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      long_flag_q <= long_flag_d;
      valid       <= valid_d;
      key_short   <= key_short_d;
      key_long    <= key_long_d;
`ifdef AUTO_OFF_EN
      ao_cnt_q    <= ao_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_key_breath_ctrl.sv
// Directed bench for key_breath_ctrl with short debounce/long/auto-off timings.
module tb_key_breath_ctrl;
  import key_ctrl_pkg::*;

  logic sys_clk;
  logic rst;
  logic key_in;
  logic valid;
  logic key_short;
  logic key_long;

  int tests_run    = 0;
  int tests_failed = 0;
  int short_cnt    = 0;
  int long_cnt     = 0;

  key_breath_ctrl #(
    .DEBOUNCE_CYC (4),
    .LONG_CYC     (20),
    .AUTO_OFF_CYC (50)
  ) dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .key_in    (key_in),
    .valid     (valid),
    .key_short (key_short),
    .key_long  (key_long)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Pulse counters sampled just after each active edge.
  always @(posedge sys_clk) begin
    #1;
    if (key_short === 1'b1) short_cnt++;
    if (key_long === 1'b1) long_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    key_in = 1'b0;
    tick(3);
    tests_run++;
    if (valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", valid); end
    tests_run++;
    if (key_short !== 1'b0 || key_long !== 1'b0) begin
      tests_failed++; $display("FAIL reset_pulses: got short=%b long=%b want 0 0", key_short, key_long);
    end
    tests_run++;
    if (short_cnt != 0 || long_cnt != 0) begin
      tests_failed++; $display("FAIL reset_pulse_count: got short=%0d long=%0d want 0 0", short_cnt, long_cnt);
    end
    rst = 1'b0;
    key_in = 1'b1;
    tick(2);
    tests_run++;
    if (dut.state_q !== KEY_IDLE) begin
      tests_failed++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, KEY_IDLE);
    end
  endtask

  task automatic test_short_press;
    int s0;
    s0 = short_cnt;
    key_in = 1'b0;
    tick(10);
    key_in = 1'b1;
    tick(5);
    tests_run++;
    if (valid !== 1'b0 || short_cnt - s0 != 0) begin
      tests_failed++; $display("FAIL short1_early: got valid=%b shorts=%0d want 0 0", valid, short_cnt - s0);
    end
    tick(1);
    tests_run++;
    if (valid !== 1'b1) begin tests_failed++; $display("FAIL short1_valid: got %b want 1", valid); end
    tests_run++;
    if (short_cnt - s0 != 1) begin tests_failed++; $display("FAIL short1_pulse: got %0d want 1", short_cnt - s0); end
    tick(4);
    tests_run++;
    if (short_cnt - s0 != 1 || valid !== 1'b1) begin
      tests_failed++; $display("FAIL short1_settle: got shorts=%0d valid=%b want 1 1", short_cnt - s0, valid);
    end
    key_in = 1'b0;
    tick(10);
    key_in = 1'b1;
    tick(6);
    tests_run++;
    if (valid !== 1'b0) begin tests_failed++; $display("FAIL short2_valid: got %b want 0", valid); end
    tests_run++;
    if (short_cnt - s0 != 2) begin tests_failed++; $display("FAIL short2_pulse: got %0d want 2", short_cnt - s0); end
    tick(2);
  endtask

  task automatic test_bounce;
    int s0;
    int l0;
    s0 = short_cnt;
    l0 = long_cnt;
    key_in = 1'b0; tick(2);
    key_in = 1'b1; tick(1);
    key_in = 1'b0; tick(2);
    key_in = 1'b1; tick(12);
    tests_run++;
    if (short_cnt - s0 != 0 || long_cnt - l0 != 0) begin
      tests_failed++; $display("FAIL bounce_press: got short=%0d long=%0d want 0 0", short_cnt - s0, long_cnt - l0);
    end
    tests_run++;
    if (valid !== 1'b0) begin tests_failed++; $display("FAIL bounce_valid: got %b want 0", valid); end
    // Low glitch while the release is being debounced.
    key_in = 1'b0; tick(10);
    key_in = 1'b1; tick(2);
    key_in = 1'b0; tick(1);
    key_in = 1'b1; tick(5);
    tests_run++;
    if (valid !== 1'b0 || short_cnt - s0 != 0) begin
      tests_failed++; $display("FAIL glitch_early: got valid=%b shorts=%0d want 0 0", valid, short_cnt - s0);
    end
    tick(1);
    tests_run++;
    if (valid !== 1'b1 || short_cnt - s0 != 1) begin
      tests_failed++; $display("FAIL glitch_release: got valid=%b shorts=%0d want 1 1", valid, short_cnt - s0);
    end
    tick(3);
  endtask

  task automatic test_long_press;
    int s0;
    int l0;
    s0 = short_cnt;
    l0 = long_cnt;
    key_in = 1'b0;
    tick(25);
    tests_run++;
    if (valid !== 1'b1 || long_cnt - l0 != 0) begin
      tests_failed++; $display("FAIL long_early: got valid=%b longs=%0d want 1 0", valid, long_cnt - l0);
    end
    tick(1);
    tests_run++;
    if (key_long !== 1'b1 || valid !== 1'b0) begin
      tests_failed++; $display("FAIL long_fire: got key_long=%b valid=%b want 1 0", key_long, valid);
    end
    tick(1);
    tests_run++;
    if (key_long !== 1'b0) begin tests_failed++; $display("FAIL long_width: got %b want 0", key_long); end
    tick(13);
    key_in = 1'b1;
    tick(10);
    tests_run++;
    if (short_cnt - s0 != 0 || long_cnt - l0 != 1) begin
      tests_failed++; $display("FAIL long_release: got short=%0d long=%0d want 0 1", short_cnt - s0, long_cnt - l0);
    end
    tests_run++;
    if (valid !== 1'b0) begin tests_failed++; $display("FAIL long_valid: got %b want 0", valid); end
  endtask

  task automatic test_auto_off;
    key_in = 1'b0;
    tick(10);
    key_in = 1'b1;
    tick(6);
    tests_run++;
    if (valid !== 1'b1) begin tests_failed++; $display("FAIL auto_set: got %b want 1", valid); end
`ifdef AUTO_OFF_EN
    tick(49);
    tests_run++;
    if (valid !== 1'b1) begin tests_failed++; $display("FAIL auto_hold: got %b want 1", valid); end
    tick(1);
    tests_run++;
    if (valid !== 1'b0) begin tests_failed++; $display("FAIL auto_off: got %b want 0", valid); end
`else
    tick(200);
    tests_run++;
    if (valid !== 1'b1) begin tests_failed++; $display("FAIL no_auto_off: got %b want 1", valid); end
`endif
  endtask

  task automatic test_reset_mid_hold;
    int s0;
    int l0;
    l0 = long_cnt;
    key_in = 1'b0;
    tick(16);
    rst = 1'b1;
    tick(3);
    tests_run++;
    if (valid !== 1'b0 || key_short !== 1'b0 || key_long !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got valid=%b short=%b long=%b want 0 0 0", valid, key_short, key_long);
    end
    rst = 1'b0;
    key_in = 1'b1;
    tick(30);
    tests_run++;
    if (long_cnt - l0 != 0 || valid !== 1'b0) begin
      tests_failed++; $display("FAIL midreset_quiet: got longs=%0d valid=%b want 0 0", long_cnt - l0, valid);
    end
    s0 = short_cnt;
    key_in = 1'b0;
    tick(10);
    key_in = 1'b1;
    tick(5);
    tests_run++;
    if (valid !== 1'b0) begin tests_failed++; $display("FAIL fresh_early: got %b want 0", valid); end
    tick(1);
    tests_run++;
    if (valid !== 1'b1 || short_cnt - s0 != 1) begin
      tests_failed++; $display("FAIL fresh_press: got valid=%b shorts=%0d want 1 1", valid, short_cnt - s0);
    end
  endtask

  initial begin
    rst = 1'b1;
    key_in = 1'b1;
    test_reset;
    test_short_press;
    test_bounce;
    test_long_press;
    test_auto_off;
    test_reset_mid_hold;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
